// File: rtl/ieee_754_ln_floor_if.sv
// rtl/ieee_754_ln_floor_if.sv - operand/result handshake bundle for ieee_754_ln_floor
interface ieee_754_ln_floor_if #(
    parameter int OUT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [2:0]       out_flags;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_flags
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_flags
    );
endinterface

// File: rtl/ieee_754_ln_floor.sv
// rtl/ieee_754_ln_floor.sv - floor(ln x) of a single-precision operand via 4-step ROM binary search
// Optional special-input counter: IEEE_754_LN_STATS_EN
module ieee_754_ln_floor #(
    parameter int OUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ieee_754_ln_floor_if.slave   bus
`ifdef IEEE_754_LN_STATS_EN
    ,
    output logic [15:0]          stat_special
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLASS  = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Magnitudes of the single-precision values nearest e^k; sign bit is always 0.
    function automatic logic [30:0] t_rom(input logic [3:0] k);
        logic [30:0] t;
        case (k)
            4'd0:    t = 31'h3F800000;
            4'd1:    t = 31'h402DF854;
            4'd2:    t = 31'h40EC7326;
            4'd3:    t = 31'h41A0AF2E;
            4'd4:    t = 31'h425A6481;
            4'd5:    t = 31'h431469C5;
            4'd6:    t = 31'h43C9B6E3;
            4'd7:    t = 31'h44891443;
            4'd8:    t = 31'h453A4F54;
            4'd9:    t = 31'h45FD38AC;
            4'd10:   t = 31'h46AC14EE;
            default: t = 31'h4769E224;
        endcase
        return t;
    endfunction

    state_t           state_q;
    logic [31:0]      x_q;
    logic [3:0]       lo_q;
    logic [3:0]       hi_q;
    logic [1:0]       cnt_q;
    logic [OUT_W-1:0] out_data_q;
    logic [2:0]       out_flags_q;
    logic             out_valid_q;

    logic [30:0] mag;
    logic        is_nan;
    logic        is_ovf;
    logic        is_unf;
    logic [4:0]  mid_sum;
    logic [3:0]  mid;
    logic        ge_mid;
    logic [3:0]  lo_d;
    logic [3:0]  hi_d;

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_flags = out_flags_q;

    // NaN is tested first so the remaining unsigned magnitude compares are meaningful.
    always_comb begin
        mag    = x_q[30:0];
        is_nan = (x_q[30:23] == 8'hFF) && (x_q[22:0] != 23'd0);
        is_ovf = !x_q[31] && (mag >= t_rom(4'd11));
        is_unf = x_q[31] || (mag < t_rom(4'd0));
    end

    always_comb begin
        mid_sum = {1'b0, lo_q} + {1'b0, hi_q} + 5'd1;
        mid     = mid_sum[4:1];
        ge_mid  = mag >= t_rom(mid);
        lo_d    = lo_q;
        hi_d    = hi_q;
        if (lo_q != hi_q) begin
            if (ge_mid) begin
                lo_d = mid;
            end else begin
                hi_d = mid - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= 32'd0;
            lo_q        <= 4'd0;
            hi_q        <= 4'd0;
            cnt_q       <= 2'd0;
            out_data_q  <= '0;
            out_flags_q <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        x_q     <= bus.in_data;
                        state_q <= CLASS;
                    end
                end
                CLASS: begin
                    if (is_nan) begin
                        out_data_q  <= '0;
                        out_flags_q <= 3'b100;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (is_unf) begin
                        out_data_q  <= '0;
                        out_flags_q <= 3'b001;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (is_ovf) begin
                        out_data_q  <= '1;
                        out_flags_q <= 3'b010;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        lo_q    <= 4'd0;
                        hi_q    <= 4'd10;
                        cnt_q   <= 2'd0;
                        state_q <= SEARCH;
                    end
                end
                SEARCH: begin
                    lo_q  <= lo_d;
                    hi_q  <= hi_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        out_data_q  <= OUT_W'(lo_d);
                        out_flags_q <= 3'b000;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        out_data_q  <= '0;
                        out_flags_q <= 3'b000;
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef IEEE_754_LN_STATS_EN
    logic [15:0] stat_special_q;
    logic        special_hit;

    assign special_hit  = (state_q == CLASS) && (is_nan || is_ovf || is_unf);
    assign stat_special = stat_special_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_special_q <= 16'd0;
        end else if (special_hit && (stat_special_q != 16'hFFFF)) begin
            stat_special_q <= stat_special_q + 16'd1;
        end
    end
`endif

endmodule

// File: doc/ieee_754_ln_floor.md
IEEE_754_LN_FLOOR -- requirements
Module: ieee_754_ln_floor

Interface
- REQ-001: Parameter OUT_W, default 8, sets the integer result width; legal range is 4 or greater; the overflow code is all ones.
- REQ-002: clk, input, 1 bit: the only clock; all state updates on its rising edge.
- REQ-003: rst, input, 1 bit: synchronous, active-high reset.
- REQ-004: in_valid, input, 1 bit: in_data is valid this cycle.
- REQ-005: in_ready, output, 1 bit: block can accept; an input transfers when in_valid && in_ready at a rising edge.
- REQ-006: in_data, input, 32 bits: IEEE-754 single-precision operand x.
- REQ-007: out_valid, output, 1 bit: result is valid.
- REQ-008: out_ready, input, 1 bit: consumer accepts; the result transfers when out_valid && out_ready at a rising edge.
- REQ-009: out_data, output, OUT_W bits: integer result.
- REQ-010: out_flags, output, 3 bits: {nan, ovf, unf}.

Function
- REQ-011: The block SHALL compute out_data = floor(ln x) for 1.0 <= x < T[11], giving 0..10, where T[k] is the single-precision value nearest e^k, held in a ROM for k=0..11 (T[0]=0x3F800000, T[1]=0x402DF854).
- REQ-012: Magnitude compares SHALL be unsigned compares of bits [30:0]; this is valid because specials are excluded first.
- REQ-013: FSM states SHALL be IDLE, CLASS, SEARCH, DONE; in_ready = (state==IDLE) && !rst; out_valid = (state==DONE).
- REQ-014: IDLE -> CLASS on input transfer; x is captured in that same cycle.
- REQ-015: CLASS SHALL go directly to DONE for specials:
  - exponent=0xFF with mantissa!=0: out_data 0, flags 100.
  - x >= T[11], including +inf: out_data all ones, flags 010.
  - sign=1 (including -0, -inf), zero, subnormal, or x < 1.0: out_data 0, flags 001.
- REQ-016: Otherwise CLASS SHALL go to SEARCH with lo=0, hi=10 and flags 000.
- REQ-017: SEARCH SHALL run exactly 4 cycles. Each cycle: mid=(lo+hi+1)>>1; if x >= T[mid] then lo=mid, else hi=mid-1; once lo==hi, lo and hi hold. After the 4th cycle the state is DONE with out_data=lo.
- REQ-018: Latency from the input-transfer edge to out_valid high SHALL be 1 edge for specials and 5 edges for normal inputs.
- REQ-019: In DONE, out_data and out_flags SHALL hold stable until the output transfer; DONE -> IDLE on that transfer.
- REQ-020: No overlap: in_ready stays 0 from the input transfer until the cycle after the output transfer.
- REQ-021: out_data and out_flags SHALL be 0 whenever out_valid is 0.

Reset
- REQ-022: rst at any edge SHALL force IDLE and clear lo, hi, the captured x, out_data, out_flags and out_valid; an in-flight operand is discarded.
- REQ-023: in_ready SHALL be 0 during any cycle rst is high and 1 in the first cycle after rst deasserts.

Configuration
- REQ-024: With macro IEEE_754_LN_STATS_EN defined, the block SHALL add output stat_special (16 bits).
  - stat_special increments at each CLASS -> DONE special transition.
  - It saturates at 0xFFFF and is cleared by rst.
- REQ-025: Without IEEE_754_LN_STATS_EN, the stat_special port and its logic SHALL be absent; all other behaviour is identical.

Verification
- REQ-026: Inputs 0x3F800000 (1.0) -> 0; 0x41000000 (8.0) -> 2; 0x42C80000 (100.0) -> 4; 0x46EA6000 (30000.0) -> 10. Each has flags 000 and out_valid exactly 5 edges after accept.
- REQ-027: Special inputs, each with out_valid 1 edge after accept:
  - 0x7F800000 -> 0xFF, flags 010.
  - 0x47C35000 (1e5) -> 0xFF, flags 010.
  - 0x7FC00000 -> 0, flags 100.
  - 0x3F000000 (0.5) -> 0, flags 001.
  - 0xBF800000 -> 0, flags 001.
  - 0x80000000 -> 0, flags 001.
  - 0x00000001 -> 0, flags 001.
- REQ-028: Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: out_data and out_flags stable, in_ready=0 throughout; after the transfer, in_ready=1 on the next cycle with out_valid=0.
- REQ-029: Mid-operation reset: assert rst for 1 cycle during the 2nd SEARCH cycle. Required: out_valid=0 and in_ready=0 during rst, in_ready=1 next cycle, no stale result. A following 8.0 input -> 2.
- REQ-030: Boundaries: T[10] exactly -> 10; T[10]-1 ulp -> 9; T[11]-1 ulp -> 10; T[11] -> 0xFF, ovf.
- REQ-031: With IEEE_754_LN_STATS_EN: 3 specials and 2 normals -> stat_special=3; then rst -> 0.
